// File: rtl/seq_right_shifter_if.sv
// rtl/seq_right_shifter_if.sv - request/result bundle for the log-staged right shifter
interface seq_right_shifter_if #(
    parameter int N    = 8,
    parameter int LOGN = 3
);
    logic            start;
    logic [N-1:0]    data_in;
    logic [LOGN-1:0] shamt;
    logic            arith;
    logic            busy;
    logic            done;
    logic [N-1:0]    data_out;

    modport master (
        output start, data_in, shamt, arith,
        input  busy, done, data_out
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output busy, done, data_out
    );
endinterface

// File: rtl/seq_right_shifter.sv
// rtl/seq_right_shifter.sv - sequential right shifter, one power-of-two stage per cycle
module seq_right_shifter #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input logic              clk,
    input logic              rst_n,
    seq_right_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

    state_t          state;
    logic [N-1:0]    work;
    logic [LOGN-1:0] shamt_q;
    logic [LOGN-1:0] stage;
    logic            fill_q;
    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    data_out_q;

    logic [LOGN-1:0] stage_bit;
    logic [N-1:0]    shifted;
    logic [N-1:0]    stage_out;

    // stage_bit is both the 2^k shift distance and the mask selecting shamt[k]
    always_comb begin
        stage_bit = LOGN'(1) << stage;
        shifted   = N'({{N{fill_q}}, work} >> stage_bit);
        stage_out = (|(shamt_q & stage_bit)) ? shifted : work;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            work       <= '0;
            shamt_q    <= '0;
            stage      <= '0;
            fill_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work    <= bus.data_in;
                        shamt_q <= bus.shamt;
                        fill_q  <= bus.arith & bus.data_in[N-1];
                        stage   <= '0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    if (stage == LAST_STAGE) begin
                        data_out_q <= stage_out;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        stage <= stage + LOGN'(1);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 Parameter N, default 8, data width in bits; SHALL be a power of two and at least 2.
REQ-002 Parameter LOGN, default 3, shift-amount width; SHALL equal log2(N).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-006 data_in  input  N  operand, captured on the accepting edge.
REQ-007 shamt  input  LOGN  right-shift amount 0..N-1, captured on the accepting edge.
REQ-008 arith  input  1  fill mode, captured on the accepting edge: 1 = sign-bit fill, 0 = zero fill.
REQ-009 busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-010 done  output  1  single-cycle pulse marking a valid result on data_out.
REQ-011 data_out  output  N  result register.

Function
REQ-012 FSM states SHALL be exactly IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge: SHALL capture data_in into the working register, capture shamt and arith, clear the stage counter, and go to SHIFT.
REQ-014 IDLE with start=0: SHALL remain in IDLE with no register change.
REQ-015 SHIFT, stage k (k = 0..LOGN-1), one stage per edge: if captured shamt[k]=1, the working register SHALL shift right by 2^k; otherwise it holds.
REQ-016 Vacated MSBs SHALL be filled with the captured sign bit (working[N-1] at capture) when arith=1, else with 0.
REQ-017 The shift SHALL be log-staged, one stage per cycle. No per-bit serial shifting and no single-cycle full barrel.
REQ-018 At the edge completing stage LOGN-1: data_out SHALL load the final working value, done SHALL go 1, and the state SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle. The next edge SHALL return to IDLE with done=0.
REQ-020 Latency SHALL be fixed regardless of shamt: done is high during the cycle following the (LOGN+1)th edge counted from the accepting edge inclusive. That is LOGN+1 cycles after acceptance.
REQ-021 shamt=0 SHALL still take the full latency and return data_in unchanged.
REQ-022 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-024 Changes to data_in, shamt or arith after acceptance SHALL NOT affect the operation in flight.
REQ-025 data_out SHALL hold its last result until the next completion.
REQ-026 data_out SHALL change only at the completion edge.
REQ-027 start held high continuously SHALL be accepted on the first edge in IDLE after each DONE. Back-to-back period is LOGN+2 cycles.

Reset
REQ-028 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, data_out=0, and clear the working register and stage counter, from any state including mid-SHIFT.
REQ-029 An operation aborted by reset SHALL NOT produce done or update data_out.
REQ-030 start SHALL NOT be accepted on an edge where rst_n=0; the first possible acceptance is the edge after rst_n returns to 1.

Verification (N=8, LOGN=3)
REQ-031 start, data_in=0xB6, shamt=3, arith=0 -> done pulses 4 cycles later, data_out=0x16, busy high for exactly 4 cycles.
REQ-032 start, data_in=0xB6, shamt=3, arith=1 -> data_out=0xF6; and data_in=0x80, shamt=7, arith=1 -> 0xFF, while arith=0 -> 0x01.
REQ-033 start, data_in=0x5A, shamt=0 -> done after the same 4-cycle latency, data_out=0x5A.
REQ-034 Accept 0xB6/shamt=3/arith=0, then drive start=1 with data_in=0xFF on the next 2 cycles -> data_out=0x16 only, exactly one done pulse.
REQ-035 Accept an operation, assert rst_n=0 during SHIFT stage 1 -> busy=0, done never pulses, data_out=0x00; a fresh start after release completes normally.
REQ-036 start held at 1 with constant inputs 0x40/shamt=1/arith=0 -> done every 5 cycles, data_out=0x20 each time.
